key_led_ctrl: RTL

- Controller that sequences the board LED from one push-button. Debounces the raw key, emits a one-cycle press pulse, and steps a 4-mode LED state machine on each press.
- Modes: OFF, ON, slow blink, fast blink.
- Sits between the key pin and the LED pin, in the slot the simple registered key-to-LED path occupied.

---
 rtl/key_led_pkg.sv | 31 +++
 rtl/key_debounce.sv | 53 +++++
 rtl/key_led_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/key_led_pkg.sv
// Shared mode encoding and 50 MHz timing defaults for the key/LED controller.
package key_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_ON   = 2'd1,
    MODE_SLOW = 2'd2,
    MODE_FAST = 2'd3
  } mode_e;

  localparam int CNT_MAX_DEF        = 999_999;
  localparam int BLINK_SLOW_MAX_DEF = 24_999_999;
  localparam int BLINK_FAST_MAX_DEF = 4_999_999;
  localparam int LONG_MAX_DEF       = 99_999_999;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic mode_e next_mode(input mode_e cur);
    mode_e nxt;
    unique case (cur)
      MODE_OFF:  nxt = MODE_ON;
      MODE_ON:   nxt = MODE_SLOW;
      MODE_SLOW: nxt = MODE_FAST;
      default:   nxt = MODE_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-FF synchroniser, debounce counter and one-cycle press pulse for an
// active-low push-button. Usable standalone for any key input.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int CNT_MAX = CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_stable,
  output logic key_flag
);

  localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX);

  logic          key_p0;
  logic          key_p1;
  logic [CW-1:0] cnt;

  // stage p0/p1: synchroniser, resets to the released level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
    end else begin
      key_p0 <= key_in;
      key_p1 <= key_p0;
    end
  end

  // stage p2: accept a level only after CNT_MAX+1 stable cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      key_stable <= 1'b1;
      key_flag   <= 1'b0;
    end else begin
      key_flag <= 1'b0;
      if (key_p1 == key_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt        <= '0;
        key_stable <= key_p1;
        key_flag   <= ~key_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/key_led_ctrl.sv
// Single-button LED sequencer: OFF -> ON -> SLOW blink -> FAST blink.
// Define KEY_LED_LONG_PRESS_EN to add a long-press return to OFF.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int CNT_MAX        = CNT_MAX_DEF,
  parameter int BLINK_SLOW_MAX = BLINK_SLOW_MAX_DEF,
  parameter int BLINK_FAST_MAX = BLINK_FAST_MAX_DEF,
  parameter int LONG_MAX       = LONG_MAX_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       led_out,
  output logic [1:0] mode,
  output logic       key_flag
);

  localparam int BW = $clog2(max_int(BLINK_SLOW_MAX, BLINK_FAST_MAX) + 1);
  localparam logic [BW-1:0] SLOW_LAST = BW'(BLINK_SLOW_MAX);
  localparam logic [BW-1:0] FAST_LAST = BW'(BLINK_FAST_MAX);

  logic          key_stable;
  logic          long_hit;
  mode_e         mode_q;
  mode_e         mode_d;
  logic          mode_chg;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_last;
  logic          led_q;

  key_debounce #(
    .CNT_MAX(CNT_MAX)
  ) u_debounce (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .key_in    (key_in),
    .key_stable(key_stable),
    .key_flag  (key_flag)
  );

`ifdef KEY_LED_LONG_PRESS_EN
  localparam int LW = (LONG_MAX > 0) ? $clog2(LONG_MAX + 1) : 1;
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX);

  logic [LW-1:0] long_cnt;
  logic          long_done;

  // one override per hold: long_done blocks repeats until release
  assign long_hit = ~key_stable & (long_cnt == LONG_LAST) & ~long_done;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
    end else if (key_stable) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
    end else begin
      if (long_cnt != LONG_LAST) begin
        long_cnt <= long_cnt + LW'(1);
      end
      if (long_hit) begin
        long_done <= 1'b1;
      end
    end
  end
`else
  localparam int LONG_MAX_UNUSED = LONG_MAX;
  logic key_stable_unused;

  assign key_stable_unused = key_stable;
  assign long_hit          = 1'b0;
`endif

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q <= MODE_OFF;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (key_flag) begin
      mode_d = next_mode(mode_q);
    end
    if (long_hit) begin
      mode_d = MODE_OFF;
    end
  end

  always_comb begin
    mode    = mode_q;
    led_out = led_q;
  end

  assign mode_chg   = (mode_d != mode_q);
  assign blink_last = (mode_q == MODE_SLOW) ? SLOW_LAST : FAST_LAST;

  // a mode change outranks a coincident blink wrap; blink modes start lit
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      blink_cnt <= '0;
      led_q     <= 1'b0;
    end else if (mode_chg) begin
      blink_cnt <= '0;
      led_q     <= (mode_d != MODE_OFF);
    end else begin
      unique case (mode_q)
        MODE_OFF: begin
          blink_cnt <= '0;
          led_q     <= 1'b0;
        end
        MODE_ON: begin
          blink_cnt <= '0;
          led_q     <= 1'b1;
        end
        default: begin
          if (blink_cnt == blink_last) begin
            blink_cnt <= '0;
            led_q     <= ~led_q;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
      endcase
    end
  end

endmodule
